// File: rtl/spi_slave_param.sv
// SPI slave: {cmd[1:0], payload} frames with read-address / read-data
// sequencing and a memory-side tx handshake for read responses.
module spi_slave_param #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              MISO,
  output logic              rx_valid,
  output logic [DATA_W+1:0] rx_data,
  output logic              frame_err
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int CW      = $clog2(FRAME_W) + 1;
  localparam int TW      = $clog2(DATA_W) + 1;

  localparam logic [CW-1:0] LAST    = CW'(FRAME_W - 1);
  localparam logic [TW-1:0] TX_LAST = TW'(DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADDR,
    READ_DATA,
    TX,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]      cnt;
  logic [FRAME_W-2:0] sr;
  logic               rd_addr_seen;
  logic [DATA_W-1:0]  tx_sr;
  logic [TW-1:0]      tx_cnt;
  logic               tx_busy;

  logic shift_en;
  logic last_bit;
  logic abort;
  logic tx_load;
  logic tx_step;
  logic tx_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    shift_en = 1'b0;
    last_bit = 1'b0;
    abort    = 1'b0;
    tx_load  = 1'b0;
    tx_step  = 1'b0;
    tx_end   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!SS_n) state_nx = CHK_CMD;
      end
      CHK_CMD: begin
        if (SS_n) begin
          abort = 1'b1;
        end else begin
          shift_en = 1'b1;
          if (!MOSI)             state_nx = WRITE;
          else if (rd_addr_seen) state_nx = READ_DATA;
          else                   state_nx = READ_ADDR;
        end
      end
      WRITE, READ_ADDR, READ_DATA: begin
        if (SS_n) begin
          abort = 1'b1;
        end else begin
          shift_en = 1'b1;
          if (cnt == LAST) begin
            last_bit = 1'b1;
            state_nx = (state == READ_DATA) ? TX : DONE;
          end
        end
      end
      TX: begin
        if (SS_n) begin
          abort = 1'b1;
        end else if (!tx_busy) begin
          tx_load = tx_valid;
        end else if (tx_cnt == TX_LAST) begin
          tx_end   = 1'b1;
          state_nx = DONE;
        end else begin
          tx_step = 1'b1;
        end
      end
      DONE: begin
        if (SS_n) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  // Receive path: sr collects the frame, rx_data only updates on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      sr           <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
      rd_addr_seen <= 1'b0;
    end else begin
      rx_valid  <= last_bit;
      frame_err <= abort;
      if (state == IDLE || abort || last_bit) cnt <= '0;
      else if (shift_en)                      cnt <= cnt + CW'(1);
      if (shift_en) sr <= {sr[FRAME_W-3:0], MOSI};
      if (last_bit) rx_data <= {sr, MOSI};
      if (last_bit && state == READ_ADDR) rd_addr_seen <= 1'b1;
      else if (tx_end)                    rd_addr_seen <= 1'b0;
    end
  end

  // Transmit path: MSB leaves on the capture edge, then one bit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr   <= '0;
      tx_cnt  <= '0;
      tx_busy <= 1'b0;
      MISO    <= 1'b0;
    end else if (tx_load) begin
      tx_sr   <= {tx_data[DATA_W-2:0], 1'b0};
      tx_cnt  <= TW'(1);
      tx_busy <= 1'b1;
      MISO    <= tx_data[DATA_W-1];
    end else if (tx_step) begin
      tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
      tx_cnt <= tx_cnt + TW'(1);
      MISO   <= tx_sr[DATA_W-1];
    end else begin
      tx_cnt  <= '0;
      tx_busy <= 1'b0;
      MISO    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: 8-bit and 16-bit payload instances
// sharing the serial inputs.
module tb_spi_slave_param;

  logic        clk;
  logic        rst_n;
  logic        SS_n;
  logic        MOSI;
  logic        tx_valid;
  logic [7:0]  tx_data8;
  logic [15:0] tx_data16;

  logic        miso8, rxv8, ferr8;
  logic [9:0]  rxd8;
  logic        miso16, rxv16, ferr16;
  logic [17:0] rxd16;

  int checks = 0;
  int errors = 0;
  int rxv8_n = 0;
  int ferr8_n = 0;
  int rxv16_n = 0;

  spi_slave_param #(.DATA_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI),
    .tx_valid(tx_valid), .tx_data(tx_data8),
    .MISO(miso8), .rx_valid(rxv8), .rx_data(rxd8),
    .frame_err(ferr8)
  );

  spi_slave_param #(.DATA_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI),
    .tx_valid(tx_valid), .tx_data(tx_data16),
    .MISO(miso16), .rx_valid(rxv16), .rx_data(rxd16),
    .frame_err(ferr16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strobe tallies, sampled just after each active edge
  always begin
    @(posedge clk);
    #1;
    rxv8_n  += int'(rxv8);
    ferr8_n += int'(ferr8);
    rxv16_n += int'(rxv16);
  end

  task automatic send_frame(input int fw, input logic [17:0] f);
    SS_n = 1'b0;
    MOSI = f[fw-1];
    for (int i = fw - 1; i >= 0; i--) begin
      @(negedge clk);
      MOSI = f[i];
    end
  endtask

  task automatic end_frame;
    SS_n = 1'b1;
    MOSI = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (miso8 !== 1'b0) begin
      errors++; $display("FAIL reset_miso got %b exp 0", miso8);
    end
    checks++;
    if (rxv8 !== 1'b0) begin
      errors++; $display("FAIL reset_rx_valid got %b exp 0", rxv8);
    end
    checks++;
    if (rxd8 !== 10'h000) begin
      errors++; $display("FAIL reset_rx_data got %h exp 000", rxd8);
    end
    checks++;
    if (ferr8 !== 1'b0) begin
      errors++; $display("FAIL reset_frame_err got %b exp 0", ferr8);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_addr;
    int n0, f0;
    n0 = rxv8_n;
    f0 = ferr8_n;
    send_frame(10, 18'h000A5);
    checks++;
    if (rxv8_n !== n0) begin
      errors++; $display("FAIL wr_early_valid got %0d exp %0d", rxv8_n, n0);
    end
    @(negedge clk);
    checks++;
    if (rxv8 !== 1'b1) begin
      errors++; $display("FAIL wr_rx_valid got %b exp 1", rxv8);
    end
    checks++;
    if (rxd8 !== 10'h0A5) begin
      errors++; $display("FAIL wr_rx_data got %h exp 0a5", rxd8);
    end
    for (int i = 0; i < 5; i++) begin
      MOSI = ~MOSI;
      @(negedge clk);
    end
    checks++;
    if (rxv8_n !== n0 + 1) begin
      errors++; $display("FAIL wr_pulse_count got %0d exp %0d", rxv8_n, n0 + 1);
    end
    checks++;
    if (miso8 !== 1'b0) begin
      errors++; $display("FAIL wr_done_miso got %b exp 0", miso8);
    end
    end_frame();
    checks++;
    if (ferr8_n !== f0) begin
      errors++; $display("FAIL wr_done_exit_err got %0d exp %0d", ferr8_n, f0);
    end
  endtask

  task automatic test_read_seq;
    logic [7:0] exp;
    logic seen_hi;
    send_frame(10, 18'h002F0);
    @(negedge clk);
    checks++;
    if (rxv8 !== 1'b1 || rxd8 !== 10'h2F0) begin
      errors++; $display("FAIL rd_addr got v=%b d=%h exp v=1 d=2f0", rxv8, rxd8);
    end
    end_frame();
    send_frame(10, 18'h00300);
    @(negedge clk);
    checks++;
    if (rxv8 !== 1'b1 || rxd8 !== 10'h300) begin
      errors++; $display("FAIL rd_data got v=%b d=%h exp v=1 d=300", rxv8, rxd8);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (miso8 !== 1'b0) begin
      errors++; $display("FAIL tx_wait_miso got %b exp 0", miso8);
    end
    exp = 8'h3C;
    tx_valid = 1'b1;
    tx_data8 = exp;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data8 = 8'hFF;
      checks++;
      if (miso8 !== exp[i]) begin
        errors++; $display("FAIL tx_3c_bit%0d got %b exp %b", i, miso8, exp[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (miso8 !== 1'b0) begin
      errors++; $display("FAIL tx_after_miso got %b exp 0", miso8);
    end
    end_frame();
    // rd_addr_seen was cleared, so this cmd=10 frame is an address again
    send_frame(10, 18'h002C0);
    @(negedge clk);
    tx_valid = 1'b1;
    seen_hi = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      seen_hi |= miso8;
    end
    checks++;
    if (seen_hi !== 1'b0 || rxd8 !== 10'h2C0) begin
      errors++; $display("FAIL seen_cleared got miso=%b d=%h exp 0 2c0", seen_hi, rxd8);
    end
    end_frame();
  endtask

  task automatic test_abort;
    logic [4:0] bits;
    logic [7:0] exp;
    int n0;
    n0 = rxv8_n;
    bits = 5'b11010;
    SS_n = 1'b0;
    MOSI = bits[4];
    for (int i = 4; i >= 0; i--) begin
      @(negedge clk);
      MOSI = bits[i];
    end
    @(negedge clk);
    SS_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ferr8 !== 1'b1 || rxv8 !== 1'b0) begin
      errors++; $display("FAIL abort_strobe got err=%b v=%b exp 1 0", ferr8, rxv8);
    end
    @(negedge clk);
    checks++;
    if (ferr8 !== 1'b0) begin
      errors++; $display("FAIL abort_width got %b exp 0", ferr8);
    end
    checks++;
    if (rxv8_n !== n0) begin
      errors++; $display("FAIL abort_no_valid got %0d exp %0d", rxv8_n, n0);
    end
    // rd_addr_seen still set: a read frame goes straight to TX
    send_frame(10, 18'h00355);
    @(negedge clk);
    checks++;
    if (rxv8 !== 1'b1 || rxd8 !== 10'h355) begin
      errors++; $display("FAIL post_abort_rd got v=%b d=%h exp 1 355", rxv8, rxd8);
    end
    exp = 8'hA5;
    tx_valid = 1'b1;
    tx_data8 = exp;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      tx_valid = 1'b0;
      checks++;
      if (miso8 !== exp[i]) begin
        errors++; $display("FAIL tx_a5_bit%0d got %b exp %b", i, miso8, exp[i]);
      end
    end
    end_frame();
  endtask

  task automatic test_reset_tx;
    int n0, f0;
    logic seen_hi;
    send_frame(10, 18'h002AA);
    @(negedge clk);
    end_frame();
    send_frame(10, 18'h003FF);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data8 = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      checks++;
      if (miso8 !== 1'b1) begin
        errors++; $display("FAIL rst_tx_bit%0d got %b exp 1", i, miso8);
      end
    end
    n0 = rxv8_n;
    f0 = ferr8_n;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (miso8 !== 1'b0) begin
      errors++; $display("FAIL rst_tx_miso got %b exp 0", miso8);
    end
    @(negedge clk);
    @(negedge clk);
    SS_n = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rxv8_n !== n0 || ferr8_n !== f0) begin
      errors++; $display("FAIL rst_tx_strobes got v=%0d e=%0d exp v=%0d e=%0d", rxv8_n, ferr8_n, n0, f0);
    end
    checks++;
    if (rxd8 !== 10'h000) begin
      errors++; $display("FAIL rst_tx_rx_data got %h exp 000", rxd8);
    end
    send_frame(10, 18'h003C3);
    @(negedge clk);
    checks++;
    if (rxv8 !== 1'b1 || rxd8 !== 10'h3C3) begin
      errors++; $display("FAIL rst_first_frame got v=%b d=%h exp 1 3c3", rxv8, rxd8);
    end
    tx_valid = 1'b1;
    seen_hi = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      seen_hi |= miso8;
    end
    checks++;
    if (seen_hi !== 1'b0) begin
      errors++; $display("FAIL rst_seen_cleared got miso=%b exp 0", seen_hi);
    end
    end_frame();
  endtask

  task automatic test_wide;
    int n0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n0 = rxv16_n;
    send_frame(18, 18'h0BEEF);
    checks++;
    if (rxv16_n !== n0) begin
      errors++; $display("FAIL w16_early_valid got %0d exp %0d", rxv16_n, n0);
    end
    @(negedge clk);
    checks++;
    if (rxv16 !== 1'b1 || rxd16 !== 18'h0BEEF) begin
      errors++; $display("FAIL w16_frame got v=%b d=%h exp 1 0beef", rxv16, rxd16);
    end
    @(negedge clk);
    checks++;
    if (rxv16 !== 1'b0 || ferr16 !== 1'b0) begin
      errors++; $display("FAIL w16_pulse got v=%b e=%b exp 0 0", rxv16, ferr16);
    end
    end_frame();
  endtask

  initial begin
    rst_n     = 1'b0;
    SS_n      = 1'b1;
    MOSI      = 1'b0;
    tx_valid  = 1'b0;
    tx_data8  = '0;
    tx_data16 = '0;
    test_reset();
    test_write_addr();
    test_read_seq();
    test_abort();
    test_reset_tx();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_param.md
SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning payload width in bits (address or data); legal range 4..32.
REQ-002 SHALL derive FRAME_W = DATA_W+2 (2-bit command prefix + payload); not overridable.
REQ-003 SHALL have port clk  input  1  system/shift clock; all sampling and driving on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port SS_n  input  1  slave select, active-low; frame boundary.
REQ-006 SHALL have port MOSI  input  1  serial data in, MSB first.
REQ-007 SHALL have port tx_valid  input  1  tx_data valid strobe from memory side.
REQ-008 SHALL have port tx_data  input  DATA_W  read data to be shifted out.
REQ-009 SHALL have port MISO  output  1  serial data out, MSB first; registered.
REQ-010 SHALL have port rx_valid  output  1  one-cycle strobe, rx_data frame complete.
REQ-011 SHALL have port rx_data  output  FRAME_W  {cmd[1:0], payload[DATA_W-1:0]}; registered.
REQ-012 SHALL have port frame_err  output  1  one-cycle strobe, frame aborted by SS_n before completion.

Function
REQ-013 SHALL implement states IDLE, CHK_CMD, WRITE, READ_ADDR, READ_DATA, TX, DONE.
REQ-014 IDLE -> CHK_CMD when SS_n=0; else stay.
REQ-015 CHK_CMD: sample MOSI as frame bit FRAME_W-1 (cmd[1]); MOSI=0 -> WRITE; MOSI=1 & rd_addr_seen=0 -> READ_ADDR; MOSI=1 & rd_addr_seen=1 -> READ_DATA.
REQ-016 WRITE/READ_ADDR/READ_DATA: shift MOSI into rx_data LSB each cycle for FRAME_W-1 further cycles; bit counter width clog2(FRAME_W)+1.
REQ-017 After last bit: rx_valid=1 for exactly one cycle (cycle after last sample), rx_data stable from that cycle until next frame's CHK_CMD.
REQ-018 Total latency: rx_valid high FRAME_W+1 rising edges after first edge sampling SS_n=0 in IDLE.
REQ-019 WRITE, READ_ADDR complete -> DONE; READ_ADDR completion sets internal rd_addr_seen=1.
REQ-020 READ_DATA complete -> TX; TX waits indefinitely for tx_valid=1 with MISO=0.
REQ-021 TX: on edge sampling tx_valid=1, capture tx_data into shift register; following DATA_W cycles MISO drives tx_data[DATA_W-1] down to tx_data[0], one bit per cycle.
REQ-022 After bit 0 driven: rd_addr_seen cleared, MISO returns 0, -> DONE; tx_valid ignored in all states except TX-waiting.
REQ-023 DONE: ignore MOSI, hold outputs, MISO=0; -> IDLE when SS_n=1.
REQ-024 SS_n=1 in CHK_CMD/WRITE/READ_ADDR/READ_DATA/TX before completion: -> IDLE next edge, frame_err=1 one cycle, no rx_valid, counter cleared, rd_addr_seen unchanged.
REQ-025 IDLE: counter=0, rx_valid=0, MISO=0; rx_data holds last value.
REQ-026 rx_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state=IDLE, rx_data=0, rx_valid=0, MISO=0, frame_err=0, rd_addr_seen=0, counters=0, tx shift register=0.
REQ-028 Reset mid-frame SHALL discard partial frame without rx_valid or frame_err; first frame after release decodes as if rd_addr_seen=0.

Verification (DATA_W=8 unless stated)
REQ-029 Write-addr: SS_n=0, MOSI 0,0,1,0,1,0,0,1,0,1 -> rx_valid single pulse 11 edges later, rx_data=10'h0A5, state DONE until SS_n=1.
REQ-030 Read-addr then read-data: frame 10'h2F0 -> rx_data=10'h2F0, rd_addr_seen=1; next frame 10'h300 -> rx_valid, rx_data=10'h300; tx_valid with tx_data=8'h3C -> MISO 0,0,1,1,1,1,0,0 on next 8 cycles, then rd_addr_seen=0.
REQ-031 Read-data without prior read-addr: frame starting MOSI=1 after reset -> READ_ADDR path, rd_addr_seen=1 after frame.
REQ-032 Abort: SS_n=1 after 5 bits -> frame_err one-cycle pulse, no rx_valid, IDLE; rd_addr_seen unchanged.
REQ-033 Reset mid-TX after 3 MISO bits -> MISO=0 immediately, IDLE, rd_addr_seen=0, no strobes.
REQ-034 DATA_W=16: 18-bit frame 18'h0_BEEF with cmd 00 -> rx_data=18'h0BEEF, rx_valid 19 edges after SS_n sampled low.
